// File: rtl/sdram_arbiter.sv
// Single-outstanding arbiter in front of the SDRAM controller: download writes first, then read ports 0..3.
// Build option SDRAM_ARB_DOWNLOAD_EN enables the one-entry download write buffer and dl_active gating.
module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  dl_active,
    input  logic [ADDR_WIDTH-1:0] dl_addr,
    input  logic [DATA_WIDTH-1:0] dl_data,
    input  logic                  dl_wr,
    output logic                  dl_overflow,
    input  logic                  port_0_req,
    input  logic [ADDR_WIDTH-1:0] port_0_addr,
    output logic                  port_0_ack,
    output logic                  port_0_valid,
    output logic [DATA_WIDTH-1:0] port_0_q,
    input  logic                  port_1_req,
    input  logic [ADDR_WIDTH-1:0] port_1_addr,
    output logic                  port_1_ack,
    output logic                  port_1_valid,
    output logic [DATA_WIDTH-1:0] port_1_q,
    input  logic                  port_2_req,
    input  logic [ADDR_WIDTH-1:0] port_2_addr,
    output logic                  port_2_ack,
    output logic                  port_2_valid,
    output logic [DATA_WIDTH-1:0] port_2_q,
    input  logic                  port_3_req,
    input  logic [ADDR_WIDTH-1:0] port_3_addr,
    output logic                  port_3_ack,
    output logic                  port_3_valid,
    output logic [DATA_WIDTH-1:0] port_3_q,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [DATA_WIDTH-1:0] sdram_data,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  sdram_valid,
    input  logic [DATA_WIDTH-1:0] sdram_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]            req_vec;
    logic [ADDR_WIDTH-1:0] req_addr [4];
    logic [1:0]            rd_idx;
    logic                  rd_ok;
    logic                  take_dl;
    logic                  wr_grant;
    logic [1:0]            grant;
    logic [3:0]            ack_vec;
    logic [3:0]            valid_vec;
    logic [DATA_WIDTH-1:0] q_reg [4];

    assign req_vec     = {port_3_req, port_2_req, port_1_req, port_0_req};
    assign req_addr[0] = port_0_addr;
    assign req_addr[1] = port_1_addr;
    assign req_addr[2] = port_2_addr;
    assign req_addr[3] = port_3_addr;

    always_comb begin
        rd_idx = 2'd0;
        priority case (1'b1)
            req_vec[0]: rd_idx = 2'd0;
            req_vec[1]: rd_idx = 2'd1;
            req_vec[2]: rd_idx = 2'd2;
            req_vec[3]: rd_idx = 2'd3;
            default:    rd_idx = 2'd0;
        endcase
    end

`ifdef SDRAM_ARB_DOWNLOAD_EN
    logic                  dl_pending;
    logic [ADDR_WIDTH-1:0] dl_buf_addr;
    logic [DATA_WIDTH-1:0] dl_buf_data;
    logic                  wr_done;

    assign take_dl = dl_pending;
    assign rd_ok   = (|req_vec) && !dl_active;
    assign wr_done = (state == REQ) && sdram_ack && wr_grant;
    assign sdram_we = wr_grant;

    // A write landing in the same cycle as the ack refills the freed slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_pending  <= 1'b0;
            dl_overflow <= 1'b0;
            dl_buf_addr <= '0;
            dl_buf_data <= '0;
        end else if (dl_wr) begin
            if (dl_pending && !wr_done) begin
                dl_overflow <= 1'b1;
            end else begin
                dl_pending  <= 1'b1;
                dl_buf_addr <= dl_addr;
                dl_buf_data <= dl_data;
            end
        end else if (wr_done) begin
            dl_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_grant   <= 1'b0;
            sdram_data <= '0;
        end else if (state == IDLE) begin
            if (take_dl) begin
                wr_grant   <= 1'b1;
                sdram_data <= dl_buf_data;
            end else if (rd_ok) begin
                wr_grant <= 1'b0;
            end
        end
    end
`else
    logic unused_dl;

    assign unused_dl   = ^{dl_active, dl_addr, dl_data, dl_wr};
    assign take_dl     = 1'b0;
    assign rd_ok       = |req_vec;
    assign wr_grant    = 1'b0;
    assign sdram_we    = 1'b0;
    assign sdram_data  = '0;
    assign dl_overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (take_dl || rd_ok) state_next = REQ;
            REQ:  if (sdram_ack) state_next = wr_grant ? IDLE : WAIT;
            WAIT: if (sdram_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sdram_req = (state == REQ);
        ack_vec   = 4'b0000;
        if (state == REQ && sdram_ack && !wr_grant) ack_vec[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdram_addr <= '0;
            grant      <= 2'd0;
            valid_vec  <= 4'b0000;
            for (int i = 0; i < 4; i++) q_reg[i] <= '0;
        end else begin
            valid_vec <= 4'b0000;
            if (state == IDLE) begin
                if (take_dl) begin
                    sdram_addr <= dl_buf_addr_sel();
                end else if (rd_ok) begin
                    sdram_addr <= req_addr[rd_idx];
                    grant      <= rd_idx;
                end
            end
            if (state == WAIT && sdram_valid) begin
                valid_vec[grant] <= 1'b1;
                q_reg[grant]     <= sdram_q;
            end
        end
    end

    function automatic logic [ADDR_WIDTH-1:0] dl_buf_addr_sel();
`ifdef SDRAM_ARB_DOWNLOAD_EN
        return dl_buf_addr;
`else
        return '0;
`endif
    endfunction

    assign port_0_ack   = ack_vec[0];
    assign port_1_ack   = ack_vec[1];
    assign port_2_ack   = ack_vec[2];
    assign port_3_ack   = ack_vec[3];
    assign port_0_valid = valid_vec[0];
    assign port_1_valid = valid_vec[1];
    assign port_2_valid = valid_vec[2];
    assign port_3_valid = valid_vec[3];
    assign port_0_q     = q_reg[0];
    assign port_1_q     = q_reg[1];
    assign port_2_q     = q_reg[2];
    assign port_3_q     = q_reg[3];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reads, priority, download writes, overflow, reset.
// Download scenarios build only when SDRAM_ARB_DOWNLOAD_EN is defined; otherwise the macro-off scenario runs.
module tb_sdram_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dl_active = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [DW-1:0] dl_data = '0;
    logic          dl_wr = 1'b0;
    logic          dl_overflow;
    logic [3:0]    req = 4'b0000;
    logic [3:0]    ack;
    logic [3:0]    valid;
    logic [AW-1:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
    logic [DW-1:0] q0, q1, q2, q3;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_data;
    logic          sdram_we;
    logic          sdram_req;
    logic          sdram_ack = 1'b0;
    logic          sdram_valid = 1'b0;
    logic [DW-1:0] sdram_q = '0;

    int compared = 0;
    int mismatched = 0;
    int ack_cnt [4] = '{0, 0, 0, 0};
    int val_cnt [4] = '{0, 0, 0, 0};
    int we_cnt = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .dl_active(dl_active), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_wr(dl_wr), .dl_overflow(dl_overflow),
        .port_0_req(req[0]), .port_0_addr(a0), .port_0_ack(ack[0]),
        .port_0_valid(valid[0]), .port_0_q(q0),
        .port_1_req(req[1]), .port_1_addr(a1), .port_1_ack(ack[1]),
        .port_1_valid(valid[1]), .port_1_q(q1),
        .port_2_req(req[2]), .port_2_addr(a2), .port_2_ack(ack[2]),
        .port_2_valid(valid[2]), .port_2_q(q2),
        .port_3_req(req[3]), .port_3_addr(a3), .port_3_ack(ack[3]),
        .port_3_valid(valid[3]), .port_3_q(q3),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_valid(sdram_valid), .sdram_q(sdram_q)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ack[i] === 1'b1) ack_cnt[i]++;
            if (valid[i] === 1'b1) val_cnt[i]++;
        end
        if (sdram_we === 1'b1) we_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Controller model: waits for sdram_req, acks it, returns read data two cycles later.
    task automatic serve(input logic [DW-1:0] rdata, output bit got,
                         output logic [AW-1:0] addr_s, output logic we_s,
                         output logic [DW-1:0] data_s, output int waited);
        logic [3:0] acked;
        got = 0; waited = 0; addr_s = '0; we_s = 1'b0; data_s = '0;
        settle();
        while (!got && waited < 40) begin
            if (sdram_req === 1'b1) got = 1;
            else begin waited++; step(); settle(); end
        end
        if (got) begin
            addr_s = sdram_addr; we_s = sdram_we; data_s = sdram_data;
            sdram_ack = 1'b1;
            #1;
            acked = ack;
            step();
            sdram_ack = 1'b0;
            req = req & ~acked;
            if (!we_s) begin
                step(); settle();
                sdram_valid = 1'b1; sdram_q = rdata;
                step();
                sdram_valid = 1'b0; sdram_q = '0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        settle();
        compared++;
        if ({sdram_req, sdram_we, dl_overflow, ack, valid} !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {sdram_req, sdram_we, dl_overflow, ack, valid});
        end
        compared++;
        if ({sdram_addr, sdram_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_bus: got %h/%h want 0/0", sdram_addr, sdram_data);
        end
        compared++;
        if ({q0, q1, q2, q3} !== '0) begin
            mismatched++;
            $display("FAIL reset_q: got %h %h %h %h want 0", q0, q1, q2, q3);
        end
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        int ack0, val0;
        ack0 = ack_cnt[2]; val0 = val_cnt[2];
        step(); req[2] = 1'b1; a2 = 23'h001234;
        settle();
        step(); settle();
        compared++;
        if (sdram_req !== 1'b1 || sdram_addr !== 23'h001234) begin
            mismatched++;
            $display("FAIL read_grant: got req=%b addr=%h want 1/001234", sdram_req, sdram_addr);
        end
        step(); settle();
        step(); settle();
        sdram_ack = 1'b1;
        #1;
        compared++;
        if (ack !== 4'b0100) begin
            mismatched++;
            $display("FAIL read_ack: got %b want 0100", ack);
        end
        step(); sdram_ack = 1'b0; req[2] = 1'b0;
        settle();
        compared++;
        if (sdram_req !== 1'b0) begin
            mismatched++;
            $display("FAIL read_wait_req: got %b want 0", sdram_req);
        end
        repeat (4) step();
        sdram_valid = 1'b1; sdram_q = 32'hDEADBEEF;
        settle();
        compared++;
        if (valid !== 4'b0000) begin
            mismatched++;
            $display("FAIL read_valid_early: got %b want 0000", valid);
        end
        step(); sdram_valid = 1'b0; sdram_q = '0;
        settle();
        compared++;
        if (valid !== 4'b0100 || q2 !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL read_valid: got %b/%h want 0100/deadbeef", valid, q2);
        end
        step(); settle();
        compared++;
        if (valid !== 4'b0000 || q2 !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL read_hold: got %b/%h want 0000/deadbeef", valid, q2);
        end
        compared++;
        if (ack_cnt[2] - ack0 !== 1 || val_cnt[2] - val0 !== 1) begin
            mismatched++;
            $display("FAIL read_pulses: got ack=%0d val=%0d want 1/1",
                     ack_cnt[2] - ack0, val_cnt[2] - val0);
        end
    endtask

    task automatic test_priority();
        bit got; logic [AW-1:0] ad; logic we; logic [DW-1:0] dt; int w;
        int k1, k3, v1, v3;
        k1 = ack_cnt[1]; k3 = ack_cnt[3]; v1 = val_cnt[1]; v3 = val_cnt[3];
        step();
        req[1] = 1'b1; a1 = 23'h000100;
        req[3] = 1'b1; a3 = 23'h000300;
        serve(32'h11112222, got, ad, we, dt, w);
        compared++;
        if (got !== 1'b1 || ad !== 23'h000100) begin
            mismatched++;
            $display("FAIL prio_first: got %b/%h want 1/000100", got, ad);
        end
        settle();
        compared++;
        if (valid !== 4'b0010 || q1 !== 32'h11112222) begin
            mismatched++;
            $display("FAIL prio_first_valid: got %b/%h want 0010/11112222", valid, q1);
        end
        serve(32'h33334444, got, ad, we, dt, w);
        compared++;
        if (got !== 1'b1 || ad !== 23'h000300 || w !== 0) begin
            mismatched++;
            $display("FAIL prio_second: got %b/%h wait=%0d want 1/000300/0", got, ad, w);
        end
        settle();
        compared++;
        if (valid !== 4'b1000 || q3 !== 32'h33334444) begin
            mismatched++;
            $display("FAIL prio_second_valid: got %b/%h want 1000/33334444", valid, q3);
        end
        repeat (3) step();
        compared++;
        if (ack_cnt[1] - k1 !== 1 || ack_cnt[3] - k3 !== 1 ||
            val_cnt[1] - v1 !== 1 || val_cnt[3] - v3 !== 1) begin
            mismatched++;
            $display("FAIL prio_pulses: got %0d %0d %0d %0d want 1 1 1 1",
                     ack_cnt[1] - k1, ack_cnt[3] - k3, val_cnt[1] - v1, val_cnt[3] - v3);
        end
    endtask

`ifdef SDRAM_ARB_DOWNLOAD_EN
    task automatic test_download();
        bit got; logic [AW-1:0] ad; logic we; logic [DW-1:0] dt; int w;
        int k0;
        k0 = ack_cnt[0];
        step();
        dl_active = 1'b1; req[0] = 1'b1; a0 = 23'h000077;
        for (int i = 0; i < 4; i++) begin
            step();
            dl_addr = AW'(i); dl_data = 32'hD0D00000 + DW'(i); dl_wr = 1'b1;
            step();
            dl_wr = 1'b0;
            serve(32'h0, got, ad, we, dt, w);
            compared++;
            if (got !== 1'b1 || ad !== AW'(i) || we !== 1'b1 || dt !== 32'hD0D00000 + DW'(i)) begin
                mismatched++;
                $display("FAIL dl_write%0d: got %b/%h/%b/%h want 1/%h/1/%h",
                         i, got, ad, we, dt, AW'(i), 32'hD0D00000 + DW'(i));
            end
            repeat (12) step();
        end
        compared++;
        if (ack_cnt[0] - k0 !== 0 || dl_overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL dl_block: got ack=%0d ovf=%b want 0/0", ack_cnt[0] - k0, dl_overflow);
        end
        dl_active = 1'b0;
        serve(32'h12345678, got, ad, we, dt, w);
        settle();
        compared++;
        if (got !== 1'b1 || ad !== 23'h000077 || we !== 1'b0 || q0 !== 32'h12345678) begin
            mismatched++;
            $display("FAIL dl_release_read: got %b/%h/%b/%h want 1/000077/0/12345678",
                     got, ad, we, q0);
        end
        compared++;
        if (ack_cnt[0] - k0 !== 1) begin
            mismatched++;
            $display("FAIL dl_release_ack: got %0d want 1", ack_cnt[0] - k0);
        end
    endtask

    task automatic test_overflow();
        bit got; logic [AW-1:0] ad; logic we; logic [DW-1:0] dt; int w;
        int extra;
        step();
        dl_addr = 23'h000010; dl_data = 32'h11111111; dl_wr = 1'b1;
        step();
        dl_addr = 23'h000011; dl_data = 32'h22222222;
        step();
        dl_wr = 1'b0;
        settle();
        compared++;
        if (dl_overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_set: got %b want 1", dl_overflow);
        end
        serve(32'h0, got, ad, we, dt, w);
        compared++;
        if (got !== 1'b1 || ad !== 23'h000010 || we !== 1'b1 || dt !== 32'h11111111) begin
            mismatched++;
            $display("FAIL ovf_kept: got %b/%h/%b/%h want 1/000010/1/11111111", got, ad, we, dt);
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (sdram_req === 1'b1) extra++;
            step();
        end
        compared++;
        if (extra !== 0) begin
            mismatched++;
            $display("FAIL ovf_dropped: got %0d req cycles want 0", extra);
        end
        compared++;
        if (dl_overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_sticky: got %b want 1", dl_overflow);
        end
    endtask
`else
    task automatic test_macro_off();
        bit got; logic [AW-1:0] ad; logic we; logic [DW-1:0] dt; int w;
        step();
        dl_active = 1'b1;
        dl_addr = 23'h000005; dl_data = 32'hCAFECAFE; dl_wr = 1'b1;
        step();
        step();
        dl_wr = 1'b0; req[0] = 1'b1; a0 = 23'h000042;
        serve(32'h0BADF00D, got, ad, we, dt, w);
        settle();
        compared++;
        if (got !== 1'b1 || ad !== 23'h000042 || we !== 1'b0) begin
            mismatched++;
            $display("FAIL off_read: got %b/%h/%b want 1/000042/0", got, ad, we);
        end
        compared++;
        if (valid !== 4'b0001 || q0 !== 32'h0BADF00D) begin
            mismatched++;
            $display("FAIL off_valid: got %b/%h want 0001/0badf00d", valid, q0);
        end
        compared++;
        if (we_cnt !== 0 || dl_overflow !== 1'b0 || sdram_data !== '0) begin
            mismatched++;
            $display("FAIL off_dl: got we=%0d ovf=%b data=%h want 0/0/0", we_cnt, dl_overflow, sdram_data);
        end
        dl_active = 1'b0;
        step();
    endtask
`endif

    task automatic test_reset_mid_read();
        int v0, w;
        v0 = val_cnt[0];
        step();
        req[0] = 1'b1; a0 = 23'h000055;
        w = 0;
        settle();
        while (sdram_req !== 1'b1 && w < 40) begin w++; step(); settle(); end
        compared++;
        if (sdram_req !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_grant: got %b want 1", sdram_req);
        end
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0; req[0] = 1'b0;
        settle();
        reset_n = 1'b0;
        #1;
        compared++;
        if ({sdram_req, sdram_we, dl_overflow, ack, valid} !== 11'd0 ||
            {sdram_addr, sdram_data} !== '0) begin
            mismatched++;
            $display("FAIL rst_outputs: got %b %h %h want 0",
                     {sdram_req, sdram_we, dl_overflow, ack, valid}, sdram_addr, sdram_data);
        end
        compared++;
        if ({q0, q1, q2, q3} !== '0) begin
            mismatched++;
            $display("FAIL rst_q: got %h %h %h %h want 0", q0, q1, q2, q3);
        end
        step();
        reset_n = 1'b1;
        step();
        sdram_valid = 1'b1; sdram_q = 32'h0000BAD0;
        step();
        sdram_valid = 1'b0; sdram_q = '0;
        settle();
        compared++;
        if (valid !== 4'b0000 || q0 !== '0 || sdram_req !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_stray: got %b/%h/%b want 0000/0/0", valid, q0, sdram_req);
        end
        repeat (3) step();
        compared++;
        if (val_cnt[0] - v0 !== 0) begin
            mismatched++;
            $display("FAIL rst_no_valid: got %0d want 0", val_cnt[0] - v0);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
`ifdef SDRAM_ARB_DOWNLOAD_EN
        test_download();
        test_overflow();
`else
        test_macro_off();
`endif
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
